// File: rtl/adc_capture_packer.sv
// ADC capture packer: packs AD9284 sample pairs into 32-bit FIFO words.
// Optional macro CAPTURE_HEADER_EN prefixes each capture with a header word.
module adc_capture_packer #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              dv,
    input  logic [DATA_W-1:0] ch_a,
    input  logic [DATA_W-1:0] ch_b,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [31:0]       fifo_din,
    output logic [CNT_W-1:0]  word_count,
    output logic              overflow,
    output logic              capturing,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                phase_q, phase_d;
    logic [2*DATA_W-1:0] hold_q, hold_d;
    logic                wr_en_q, wr_en_d;
    logic [31:0]         din_q, din_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
`ifdef CAPTURE_HEADER_EN
    logic [15:0]         idx_q, idx_d;
`endif

    logic                start;
    logic                accept;
    logic                phase_eff;
    logic                word_vld;
    logic [31:0]         word;

    // Next-state, sample packing and FIFO write decision
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        hold_d    = hold_q;
        wr_en_d   = 1'b0;
        din_d     = din_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
`ifdef CAPTURE_HEADER_EN
        idx_d     = idx_q;
`endif
        start     = 1'b0;
        accept    = 1'b0;
        word_vld  = 1'b0;
        word      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (dv) begin
                    start   = 1'b1;
                    accept  = 1'b1;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                if (dv) begin
                    accept = 1'b1;
                end else if (phase_q) begin
                    state_d = S_FLUSH;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_FLUSH: begin
                word_vld = 1'b1;
                word     = {{(32-2*DATA_W){1'b0}}, hold_q};
                phase_d  = 1'b0;
                state_d  = S_DONE;
            end
            S_DONE: begin
                if (dv) begin
                    start   = 1'b1;
                    accept  = 1'b1;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_CAPTURE;
                end
            end
        endcase

        // A new capture never inherits a held half from the previous one
        phase_eff = start ? 1'b0 : phase_q;

        if (accept) begin
            if (!phase_eff) begin
                hold_d  = {ch_b, ch_a};
                phase_d = 1'b1;
            end else begin
                word_vld = 1'b1;
                word     = {ch_b, ch_a, hold_q};
                phase_d  = 1'b0;
            end
        end

        if (word_vld) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                din_d   = word;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

`ifdef CAPTURE_HEADER_EN
        // Header goes out one cycle ahead of the first data word
        if (start) begin
            idx_d = idx_q + 16'd1;
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                wr_en_d = 1'b1;
                din_d   = {16'hADC2, idx_q};
            end
        end
`endif
    end

    // State and registered FIFO outputs
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            phase_q <= 1'b0;
            hold_q  <= '0;
            wr_en_q <= 1'b0;
            din_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
`ifdef CAPTURE_HEADER_EN
            idx_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
            wr_en_q <= wr_en_d;
            din_q   <= din_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
`ifdef CAPTURE_HEADER_EN
            idx_q   <= idx_d;
`endif
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_din   = din_q;
    assign word_count = cnt_q;
    assign overflow   = ovf_q;
    assign capturing  = (state_q == S_CAPTURE) || (state_q == S_FLUSH);
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_adc_capture_packer.sv
// Bench for adc_capture_packer: directed scenarios plus random traffic
// against a capture-level behavioural model.
module tb_adc_capture_packer;

`ifdef CAPTURE_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic        dclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  ch_a = '0;
    logic [7:0]  ch_b = '0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [31:0] fifo_din;
    logic [15:0] word_count;
    logic        overflow;
    logic        capturing;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] got_q[$];

    adc_capture_packer #(.DATA_W(8), .CNT_W(16)) dut (
        .dclk       (dclk),
        .rst_n      (rst_n),
        .dv         (dv),
        .ch_a       (ch_a),
        .ch_b       (ch_b),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .word_count (word_count),
        .overflow   (overflow),
        .capturing  (capturing),
        .done       (done)
    );

    initial forever #5 dclk = ~dclk;

    // Behavioural model: tracks the capture as a sample count
    bit          in_cap = 0;
    bit          m_done = 0;
    bit          flush_p = 0;
    int          nsamp = 0;
    logic [15:0] hold = '0;
    logic [15:0] cap_idx = '0;
    logic        e_wr = 0;
    logic [31:0] e_din = '0;
    logic [15:0] e_cnt = '0;
    logic        e_ovf = 0;

    task automatic emit(input logic [31:0] w, input bit counted);
        if (fifo_full) begin
            e_ovf = 1'b1;
        end else begin
            e_wr  = 1'b1;
            e_din = w;
            if (counted && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
    endtask

    task automatic model_step();
        if (!rst_n) begin
            in_cap = 0; m_done = 0; flush_p = 0; nsamp = 0;
            hold = '0; cap_idx = '0;
            e_wr = 0; e_din = '0; e_cnt = '0; e_ovf = 0;
        end else begin
            e_wr = 0;
            if (flush_p) begin
                flush_p = 0;
                in_cap  = 0;
                m_done  = 1;
                emit({16'h0000, hold}, 1);
            end else if (dv) begin
                if (!in_cap) begin
                    in_cap = 1; m_done = 0; nsamp = 0;
                    e_cnt = '0; e_ovf = 0;
`ifdef CAPTURE_HEADER_EN
                    emit({16'hADC2, cap_idx}, 0);
                    cap_idx = cap_idx + 16'd1;
`endif
                end
                if (nsamp % 2 == 0) hold = {ch_b, ch_a};
                else emit({ch_b, ch_a, hold}, 1);
                nsamp++;
            end else if (in_cap) begin
                if (nsamp % 2 == 1) flush_p = 1;
                else begin
                    in_cap = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge dclk or negedge rst_n);
        model_step();
    end

    // Compare process: every falling edge, all outputs against the model
    initial forever begin
        @(negedge dclk);
        checks++;
        if ({fifo_wr_en, fifo_din, word_count, overflow, capturing, done} !==
            {e_wr, e_din, e_cnt, e_ovf, in_cap, m_done}) begin
            errors++;
            $display("FAIL cycle t=%0t: got wr=%b din=%h cnt=%0d ovf=%b cap=%b done=%b expected wr=%b din=%h cnt=%0d ovf=%b cap=%b done=%b",
                     $time, fifo_wr_en, fifo_din, word_count, overflow,
                     capturing, done, e_wr, e_din, e_cnt, e_ovf, in_cap, m_done);
        end
        if (fifo_wr_en === 1'b1) got_q.push_back(fifo_din);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] a,
                         input logic [7:0] b, input logic f);
        dv = v; ch_a = a; ch_b = b; fifo_full = f;
        @(posedge dclk);
        #1;
    endtask

    logic [7:0] nb;
    int run_left;
    logic run_dv;

    initial begin
        repeat (3) @(posedge dclk);
        #1;
        chk("reset_outputs",
            {8'h0, 8'h0, 8'h0, 3'b0, fifo_wr_en, overflow, capturing, done},
            32'h0);
        chk("reset_din", fifo_din, 32'h0);
        chk("reset_cnt", {16'h0, word_count}, 32'h0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Long capture
        got_q.delete();
        for (int n = 0; n < 16384; n++) begin
            nb = n[7:0];
            drive(1, nb, ~nb, 0);
        end
        chk("t1_last_wr", {31'h0, fifo_wr_en}, 32'h1);
        chk("t1_cnt", {16'h0, word_count}, 32'd8192);
        chk("t1_done_not_yet", {31'h0, done}, 32'h0);
        drive(0, 0, 0, 0);
        chk("t1_done", {31'h0, done}, 32'h1);
        chk("t1_ovf", {31'h0, overflow}, 32'h0);
        drive(0, 0, 0, 0);
        chk("t1_nwrites", got_q.size(), 8192 + HDR);
        chk("t1_first", got_q[HDR], 32'hFE01FF00);

        // Five samples, odd tail flushed
        got_q.delete();
        for (int i = 1; i <= 5; i++) drive(1, 8'(i), 8'(8'h10 + i), 0);
        drive(0, 0, 0, 0);
        chk("t2_flush_state", {30'h0, capturing, done}, 32'h2);
        drive(0, 0, 0, 0);
        chk("t2_flush_wr", {31'h0, fifo_wr_en}, 32'h1);
        chk("t2_flush_din", fifo_din, 32'h00001505);
        chk("t2_cnt", {16'h0, word_count}, 32'd3);
        drive(0, 0, 0, 0);
        chk("t2_nwrites", got_q.size(), 3 + HDR);
        chk("t2_w0", got_q[HDR], 32'h12021101);
        chk("t2_w1", got_q[HDR + 1], 32'h14041303);
        chk("t2_w2", got_q[HDR + 2], 32'h00001505);

        // Full during word 3 of 16 samples
        got_q.delete();
        for (int i = 0; i < 16; i++)
            drive(1, 8'(8'h20 + i), 8'(8'h40 + i), i == 5);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t3_nwrites", got_q.size(), 7 + HDR);
        chk("t3_ovf", {31'h0, overflow}, 32'h1);
        chk("t3_cnt", {16'h0, word_count}, 32'd7);
        chk("t3_after_gap", got_q[HDR + 2], 32'h47274626);

        // Reset mid-capture after three samples
        for (int i = 0; i < 3; i++) drive(1, 8'(i), 8'(i), 0);
        rst_n = 1'b0;
        #1;
        chk("t4_async_rst",
            {fifo_din[27:0], fifo_wr_en, overflow, capturing, done},
            32'h0);
        chk("t4_async_cnt", {16'h0, word_count}, 32'h0);
        dv = 1'b0;
        @(posedge dclk);
        #1;
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        got_q.delete();
        for (int i = 0; i < 4; i++) drive(1, 8'(i + 1), 8'(i + 9), 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t4_nwrites", got_q.size(), 2 + HDR);
        chk("t4_cnt", {16'h0, word_count}, 32'd2);
`ifdef CAPTURE_HEADER_EN
        chk("t4_header0", got_q[0], 32'hADC20000);
`endif

        // Two captures separated by ten idle cycles
        drive(1, 8'h31, 8'h32, 0);
`ifdef CAPTURE_HEADER_EN
        chk("t5_header1", fifo_din, 32'hADC20001);
`endif
        drive(1, 8'h33, 8'h34, 1);
        drive(1, 8'h35, 8'h36, 0);
        drive(1, 8'h37, 8'h38, 0);
        repeat (10) drive(0, 0, 0, 0);
        chk("t5_first_done", {29'h0, done, overflow, 1'b0}, 32'h6);
        chk("t5_first_cnt", {16'h0, word_count}, 32'd1);
        drive(1, 8'h41, 8'h42, 0);
        chk("t5_restart", {29'h0, done, overflow, capturing}, 32'h1);
        chk("t5_cnt_clr", {16'h0, word_count}, 32'h0);
        drive(1, 8'h43, 8'h44, 0);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);

        // Random traffic
        run_left = 0;
        run_dv = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (run_left == 0) begin
                run_dv = ~run_dv;
                run_left = run_dv ? $urandom_range(1, 12)
                                  : $urandom_range(1, 4);
            end
            run_left--;
            drive(run_dv, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 9) == 0);
        end
        repeat (4) drive(0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
